// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master/scheduler block.
//   SPI_BYTE_W   : transfer width in bits.
//   spi_mst_st_t : master FSM states.
//   idx_width()  : width of an index into n items (at least 1 bit).
package spi_pkg;

    localparam int unsigned SPI_BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        HOLD,
        GAP
    } spi_mst_st_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     : request vector, one bit per requester.
//   pointer : highest-priority index for this decision.
//   gnt     : one-hot grant, all zero when no request is present.
//   winner  : encoded index of the granted requester (0 when none).
// The winner is the first requester at or after pointer, wrapping to 0.
module rr_arbiter
    import spi_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]               req,
    input  logic [idx_width(N)-1:0]    pointer,
    output logic [N-1:0]               gnt,
    output logic [idx_width(N)-1:0]    winner
);

    localparam int unsigned IW = idx_width(N);

    logic found;

    always_comb begin
        gnt    = '0;
        winner = '0;
        found  = 1'b0;
        // First pass: indices at or above the pointer.
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (32'(i) >= 32'(pointer))) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                winner = IW'(i);
            end
        end
        // Second pass: wrap around to indices below the pointer.
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (32'(i) < 32'(pointer))) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                winner = IW'(i);
            end
        end
    end

endmodule

// File: rtl/spi_master_sched.sv
// SPI bus master with a round-robin request scheduler.
//   Clk_i, Rst_i : clock and synchronous active-high reset.
//   Req_i        : per-requester request level, held until granted.
//   ReqSlv_i     : per-requester target slave index (SW bits each).
//   ReqData_i    : per-requester byte to send (8 bits each).
//   Gnt_o        : combinational one-hot grant in the accepting IDLE cycle.
//   Done_o       : registered one-hot completion pulse to the winner.
//   RxData_o     : received byte, updated with Done_o and held.
//   Busy_o       : high in every state except IDLE.
//   sck_o/mosi_o : SPI clock (idles low) and master-out data, MSB first.
//   ss_o         : active-high slave selects, at most one high.
//   miso_i       : master-in data, sampled on each SCK rise.
// One transfer keeps ss_o high for 17*CLKDIV cycles (SETUP, 8 HIGH, 7 LOW,
// HOLD), then releases the bus for SS_GAP cycles before the next grant.
module spi_master_sched
    import spi_pkg::*;
#(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned NSLV   = 2,
    parameter int unsigned CLKDIV = 4,
    parameter int unsigned SS_GAP = 2
) (
    input  logic                              Clk_i,
    input  logic                              Rst_i,
    input  logic [NREQ-1:0]                   Req_i,
    input  logic [NREQ*idx_width(NSLV)-1:0]   ReqSlv_i,
    input  logic [NREQ*SPI_BYTE_W-1:0]        ReqData_i,
    output logic [NREQ-1:0]                   Gnt_o,
    output logic [NREQ-1:0]                   Done_o,
    output logic [SPI_BYTE_W-1:0]             RxData_o,
    output logic                              Busy_o,
    output logic                              sck_o,
    output logic                              mosi_o,
    output logic [NSLV-1:0]                   ss_o,
    input  logic                              miso_i
);

    localparam int unsigned SW    = idx_width(NSLV);
    localparam int unsigned IW    = idx_width(NREQ);
    localparam int unsigned HCMAX = (CLKDIV > SS_GAP) ? CLKDIV : SS_GAP;
    localparam int unsigned HCW   = idx_width(HCMAX);

    localparam logic [HCW-1:0] HC_LAST  = HCW'(CLKDIV - 1);
    localparam logic [HCW-1:0] GAP_LAST = HCW'(SS_GAP - 1);
    localparam logic [3:0]     BC_LAST  = 4'(SPI_BYTE_W);

    spi_mst_st_t state_q, state_d;

    logic [HCW-1:0]        hc_q, hc_d;
    logic [3:0]            bc_q, bc_d;
    logic [SPI_BYTE_W-1:0] tx_q, tx_d;
    logic [SPI_BYTE_W-1:0] rx_q, rx_d;
    logic [SW-1:0]         slv_q, slv_d;
    logic [IW-1:0]         win_q, win_d;
    logic [IW-1:0]         ptr_q, ptr_d;
    logic                  sck_q, sck_d;
    logic [NSLV-1:0]       ss_q, ss_d;
    logic                  busy_q, busy_d;
    logic [NREQ-1:0]       done_q, done_d;
    logic [SPI_BYTE_W-1:0] rxdata_q, rxdata_d;

    logic [NREQ-1:0]       arb_gnt;
    logic [IW-1:0]         arb_win;
    logic [SW-1:0]         sel_slv;
    logic [SPI_BYTE_W-1:0] sel_dat;
    logic                  hc_last;
    logic                  slv_ok;
    logic                  miso_bit;
    logic                  sel_active;

    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .req     (Req_i),
        .pointer (ptr_q),
        .gnt     (arb_gnt),
        .winner  (arb_win)
    );

    // Grants are only offered from IDLE and never while reset is applied.
    assign Gnt_o = ((state_q == IDLE) && !Rst_i) ? arb_gnt : '0;

    assign hc_last = (hc_q == HC_LAST);
    // An out-of-range slave has no select line, so MISO is floating: shift in 0.
    assign slv_ok   = (32'(slv_q) < NSLV);
    assign miso_bit = slv_ok & miso_i;

    always_comb begin
        state_d    = state_q;
        hc_d       = hc_q + 1'b1;
        bc_d       = bc_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        slv_d      = slv_q;
        win_d      = win_q;
        ptr_d      = ptr_q;
        done_d     = '0;
        rxdata_d   = rxdata_q;
        sel_slv    = '0;
        sel_dat    = '0;
        sck_d      = 1'b0;
        ss_d       = '0;
        busy_d     = 1'b0;
        sel_active = 1'b0;

        // Mux the winner's slave index and byte out of the packed request buses.
        for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) begin
                sel_slv = ReqSlv_i[i*SW +: SW];
                sel_dat = ReqData_i[i*SPI_BYTE_W +: SPI_BYTE_W];
            end
        end

        unique case (state_q)
            IDLE: begin
                hc_d = '0;
                if (|Req_i) begin
                    state_d = SETUP;
                    slv_d   = sel_slv;
                    tx_d    = sel_dat;
                    win_d   = arb_win;
                    rx_d    = '0;
                    bc_d    = '0;
                    ptr_d   = (32'(arb_win) == NREQ - 1) ? '0 : arb_win + 1'b1;
                end
            end
            SETUP, LOW: begin
                if (hc_last) begin
                    // Entering HIGH: this edge is the SCK rise, capture MISO.
                    state_d = HIGH;
                    hc_d    = '0;
                    rx_d    = {rx_q[SPI_BYTE_W-2:0], miso_bit};
                    bc_d    = bc_q + 4'd1;
                end
            end
            HIGH: begin
                if (hc_last) begin
                    hc_d = '0;
                    if (bc_q == BC_LAST) begin
                        state_d = HOLD;
                    end else begin
                        state_d = LOW;
                        tx_d    = {tx_q[SPI_BYTE_W-2:0], 1'b0};
                    end
                end
            end
            HOLD: begin
                if (hc_last) begin
                    state_d  = GAP;
                    hc_d     = '0;
                    rxdata_d = rx_q;
                    for (int i = 0; i < NREQ; i++) begin
                        done_d[i] = (32'(win_q) == i);
                    end
                end
            end
            GAP: begin
                if (hc_q == GAP_LAST) begin
                    state_d = IDLE;
                    hc_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
                hc_d    = '0;
            end
        endcase

        // Bus outputs are registered from the next state so they line up with it.
        sck_d      = (state_d == HIGH);
        busy_d     = (state_d != IDLE);
        sel_active = (state_d == SETUP) || (state_d == HIGH) ||
                     (state_d == LOW)   || (state_d == HOLD);
        for (int s = 0; s < NSLV; s++) begin
            ss_d[s] = sel_active && (32'(slv_d) == s);
        end
    end

    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            state_q  <= IDLE;
            hc_q     <= '0;
            bc_q     <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            slv_q    <= '0;
            win_q    <= '0;
            ptr_q    <= '0;
            sck_q    <= 1'b0;
            ss_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= '0;
            rxdata_q <= '0;
        end else begin
            state_q  <= state_d;
            hc_q     <= hc_d;
            bc_q     <= bc_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            slv_q    <= slv_d;
            win_q    <= win_d;
            ptr_q    <= ptr_d;
            sck_q    <= sck_d;
            ss_q     <= ss_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rxdata_q <= rxdata_d;
        end
    end

    assign sck_o    = sck_q;
    assign ss_o     = ss_q;
    assign Busy_o   = busy_q;
    assign Done_o   = done_q;
    assign RxData_o = rxdata_q;
    // tx_q is only loaded at grant and shifted on HIGH exit, so its MSB is the MOSI bit.
    assign mosi_o   = tx_q[SPI_BYTE_W-1];

endmodule
